// File: rtl/ipg_tx.sv
`default_nettype none
// ============================================================================
// Module : ipg_tx
// Places rreq/rresp/wreq message beats into all-idle 64b/66b control blocks.
// Option : define IPG_TX_RR_EN for round-robin arbitration between messages.
// Rev    : 1.0  initial release
// ============================================================================
module ipg_tx (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] encoded_tx_data,
  input  logic [1:0]  encoded_tx_hdr,
  output logic [63:0] out_encoded_tx_data,
  output logic [1:0]  out_encoded_tx_hdr,
  input  logic [55:0] s_rreq_data,
  input  logic        s_rreq_valid,
  input  logic        s_rreq_last,
  output logic        s_rreq_ready,
  input  logic [55:0] s_rresp_data,
  input  logic        s_rresp_valid,
  input  logic        s_rresp_last,
  output logic        s_rresp_ready,
  input  logic [55:0] s_wreq_data,
  input  logic        s_wreq_valid,
  input  logic        s_wreq_last,
  output logic        s_wreq_ready,
  output logic [31:0] tx_ipg_count
);

  localparam logic [1:0] HDR_CTRL  = 2'b01;
  localparam logic [7:0] TYPE_IDLE = 8'h1e;
  localparam logic [1:0] CH_RREQ   = 2'd0;
  localparam logic [1:0] CH_RRESP  = 2'd1;
  localparam logic [1:0] CH_WREQ   = 2'd2;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    LOCK_RREQ  = 2'd1,
    LOCK_RRESP = 2'd2,
    LOCK_WREQ  = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [2:0]  hold_valid_q, hold_last_q, hold_first_q, expect_first_q;
  logic [55:0] hold_data_q [3];
  logic [63:0] out_data_q, out_data_d;
  logic [1:0]  out_hdr_q;
  logic [31:0] count_q;
  logic [1:0]  rr_last_q;

  logic [2:0]  s_valid, s_last, eligible, drain, load;
  logic [55:0] s_data [3];
  logic        opp, grant_vld;
  logic [1:0]  grant_ch, ord0, ord1, ord2;
  logic [7:0]  type_code;

  function automatic logic [1:0] nxt(input logic [1:0] ch);
    return (ch == 2'd2) ? 2'd0 : ch + 2'd1;
  endfunction

  assign s_valid = {s_wreq_valid, s_rresp_valid, s_rreq_valid};
  assign s_last  = {s_wreq_last, s_rresp_last, s_rreq_last};
  assign s_data[CH_RREQ]  = s_rreq_data;
  assign s_data[CH_RRESP] = s_rresp_data;
  assign s_data[CH_WREQ]  = s_wreq_data;

  assign opp = (encoded_tx_hdr == HDR_CTRL) && (encoded_tx_data == {56'd0, TYPE_IDLE});

  assign eligible[CH_RREQ]  = hold_valid_q[CH_RREQ]  && (state_q == IDLE || state_q == LOCK_RREQ);
  assign eligible[CH_RRESP] = hold_valid_q[CH_RRESP] && (state_q == IDLE || state_q == LOCK_RRESP);
  assign eligible[CH_WREQ]  = hold_valid_q[CH_WREQ]  && (state_q == IDLE || state_q == LOCK_WREQ);

  // Priority order starts just after the most recently completed channel.
  assign ord0 = nxt(rr_last_q);
  assign ord1 = nxt(ord0);
  assign ord2 = rr_last_q;

  always_comb begin
    grant_vld = 1'b0;
    grant_ch  = ord0;
    if (opp) begin
      if (eligible[ord0]) begin
        grant_vld = 1'b1;
        grant_ch  = ord0;
      end else if (eligible[ord1]) begin
        grant_vld = 1'b1;
        grant_ch  = ord1;
      end else if (eligible[ord2]) begin
        grant_vld = 1'b1;
        grant_ch  = ord2;
      end
    end
  end

  assign drain = grant_vld ? (3'b001 << grant_ch) : 3'b000;
  assign load  = s_valid & (~hold_valid_q | drain);

  assign s_rreq_ready  = !hold_valid_q[CH_RREQ]  || drain[CH_RREQ];
  assign s_rresp_ready = !hold_valid_q[CH_RRESP] || drain[CH_RRESP];
  assign s_wreq_ready  = !hold_valid_q[CH_WREQ]  || drain[CH_WREQ];

  always_comb begin
    type_code = 8'h1a;
    if (hold_last_q[grant_ch]) begin
      type_code = 8'h0a;
    end else if (hold_first_q[grant_ch]) begin
      type_code = 8'h2a;
    end
    type_code  = type_code + {6'd0, grant_ch};
    out_data_d = grant_vld ? {hold_data_q[grant_ch], type_code} : encoded_tx_data;
  end

  always_comb begin
    state_d = state_q;
    if (grant_vld) begin
      if (hold_last_q[grant_ch]) begin
        state_d = IDLE;
      end else begin
        case (grant_ch)
          CH_RRESP: state_d = LOCK_RRESP;
          CH_WREQ:  state_d = LOCK_WREQ;
          default:  state_d = LOCK_RREQ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      out_data_q     <= {56'd0, TYPE_IDLE};
      out_hdr_q      <= HDR_CTRL;
      count_q        <= '0;
      hold_valid_q   <= '0;
      hold_last_q    <= '0;
      hold_first_q   <= '1;
      expect_first_q <= '1;
      for (int i = 0; i < 3; i++) hold_data_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      out_data_q <= out_data_d;
      out_hdr_q  <= encoded_tx_hdr;
      if (grant_vld) count_q <= count_q + 32'd1;
      for (int i = 0; i < 3; i++) begin
        if (load[i]) begin
          hold_valid_q[i]   <= 1'b1;
          hold_data_q[i]    <= s_data[i];
          hold_last_q[i]    <= s_last[i];
          hold_first_q[i]   <= expect_first_q[i];
          expect_first_q[i] <= s_last[i];
        end else if (drain[i]) begin
          hold_valid_q[i] <= 1'b0;
        end
      end
    end
  end

`ifdef IPG_TX_RR_EN
  logic [1:0] rr_last_d;
  assign rr_last_d = (grant_vld && hold_last_q[grant_ch]) ? grant_ch : rr_last_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rr_last_q <= CH_RREQ;
    else     rr_last_q <= rr_last_d;
  end
`else
  assign rr_last_q = CH_RREQ;
`endif

  assign out_encoded_tx_data = out_data_q;
  assign out_encoded_tx_hdr  = out_hdr_q;
  assign tx_ipg_count        = count_q;

endmodule
`default_nettype wire

// File: tb/tb_ipg_tx.sv
`default_nettype none
// ============================================================================
// Module : tb_ipg_tx
// Directed and randomized bench for ipg_tx against a message-level model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_ipg_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] enc_d, out_d;
  logic [1:0]  enc_h, out_h;
  logic [31:0] cnt;
  logic [55:0] sd [3];
  logic        sv [3];
  logic        sl [3];
  logic        rdy [3];

  int n_vec = 0;
  int n_err = 0;

  // Reference model: one pending beat per channel, message lock, rotation pointer.
  logic [55:0] m_data [3];
  bit          m_pv [3];
  bit          m_last [3];
  bit          m_first [3];
  bit          m_expf [3];
  int          m_lock, m_rr, m_grant;
  logic [31:0] m_cnt;
  bit          acc [3];
  int          rem [3];

  int          r;
  logic [1:0]  rh;
  logic [63:0] rd;
  logic [7:0]  ctl_types [6];

  always #5 clk = ~clk;

  ipg_tx dut (
    .clk                 (clk),
    .rst                 (rst),
    .encoded_tx_data     (enc_d),
    .encoded_tx_hdr      (enc_h),
    .out_encoded_tx_data (out_d),
    .out_encoded_tx_hdr  (out_h),
    .s_rreq_data         (sd[0]),
    .s_rreq_valid        (sv[0]),
    .s_rreq_last         (sl[0]),
    .s_rreq_ready        (rdy[0]),
    .s_rresp_data        (sd[1]),
    .s_rresp_valid       (sv[1]),
    .s_rresp_last        (sl[1]),
    .s_rresp_ready       (rdy[1]),
    .s_wreq_data         (sd[2]),
    .s_wreq_valid        (sv[2]),
    .s_wreq_last         (sl[2]),
    .s_wreq_ready        (rdy[2]),
    .tx_ipg_count        (cnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < 3; c++) begin
      m_pv[c]   = 1'b0;
      m_expf[c] = 1'b1;
      sv[c]     = 1'b0;
    end
    m_lock = -1;
    m_rr   = 0;
    m_cnt  = '0;
  endtask

  task automatic beat(input int c, input logic [55:0] d, input logic last);
    sd[c] = d;
    sl[c] = last;
    sv[c] = 1'b1;
  endtask

  // One clock of stimulus; checks combinational ready, then registered outputs.
  task automatic cyc(input logic [1:0] h, input logic [63:0] d);
    logic [63:0] exp_d;
    logic [7:0]  tc;
    bit          opp;
    bit          er [3];
    int          c;
    enc_h = h;
    enc_d = d;
    #1;
    opp = (h == 2'b01) && (d == 64'h1e);
    m_grant = -1;
    if (opp) begin
      for (int k = 1; k <= 3; k++) begin
        c = (m_rr + k) % 3;
        if (m_grant < 0 && m_pv[c] && (m_lock < 0 || m_lock == c)) m_grant = c;
      end
    end
    exp_d = d;
    if (m_grant >= 0) begin
      tc = (m_last[m_grant] ? 8'h0a : (m_first[m_grant] ? 8'h2a : 8'h1a)) + 8'(m_grant);
      exp_d = {m_data[m_grant], tc};
    end
    for (int k = 0; k < 3; k++) begin
      er[k] = !m_pv[k] || (m_grant == k);
      chk($sformatf("ready%0d", k), 64'(rdy[k]), 64'(er[k]));
    end
    @(posedge clk);
    #1;
    if (m_grant >= 0) m_cnt = m_cnt + 32'd1;
    chk("out_data", out_d, exp_d);
    chk("out_hdr", 64'(out_h), 64'(h));
    chk("count", 64'(cnt), 64'(m_cnt));
    if (m_grant >= 0) begin
      m_pv[m_grant] = 1'b0;
      if (m_last[m_grant]) begin
        m_lock = -1;
`ifdef IPG_TX_RR_EN
        m_rr = m_grant;
`endif
      end else begin
        m_lock = m_grant;
      end
    end
    for (int k = 0; k < 3; k++) begin
      acc[k] = sv[k] && er[k];
      if (acc[k]) begin
        m_pv[k]    = 1'b1;
        m_data[k]  = sd[k];
        m_last[k]  = sl[k];
        m_first[k] = m_expf[k];
        m_expf[k]  = sl[k];
        sv[k]      = 1'b0;
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int c = 0; c < 3; c++) sv[c] = 1'b0;
    #2;
    chk("rst_data", out_d, 64'h1e);
    chk("rst_hdr", 64'(out_h), 64'(2'b01));
    chk("rst_count", 64'(cnt), 64'd0);
    for (int c = 0; c < 3; c++) chk($sformatf("rst_ready%0d", c), 64'(rdy[c]), 64'd1);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    ctl_types = '{8'h2d, 8'h33, 8'h4b, 8'h87, 8'h78, 8'hff};
    rst   = 1'b1;
    enc_h = 2'b01;
    enc_d = 64'h1e;
    for (int c = 0; c < 3; c++) begin
      sd[c]  = '0;
      sl[c]  = 1'b0;
      rem[c] = 0;
    end
    model_reset();
    repeat (2) @(negedge clk);
    do_reset();

    // Pass-through of data and non-idle control
    cyc(2'b10, 64'h0123456789abcdef);
    chk("pass_data", out_d, 64'h0123456789abcdef);
    cyc(2'b01, 64'h87);
    chk("pass_ctrl", out_d, 64'h87);
    chk("pass_cnt", 64'(cnt), 64'd0);

    // Single-beat rreq
    beat(0, 56'hAABBCCDDEEFF11, 1'b1);
    cyc(2'b10, 64'h5555);
    cyc(2'b01, 64'h1e);
    chk("rreq_single", out_d, 64'hAABBCCDDEEFF110a);
    chk("rreq_cnt", 64'(cnt), 64'd1);

    // Three-beat wreq over back-to-back idles
    beat(2, 56'h1, 1'b0);
    cyc(2'b10, 64'h1111);
    beat(2, 56'h2, 1'b0);
    cyc(2'b01, 64'h1e);
    chk("wreq_b1", out_d, {56'h1, 8'h2c});
    beat(2, 56'h3, 1'b1);
    cyc(2'b01, 64'h1e);
    chk("wreq_b2", out_d, {56'h2, 8'h1c});
    cyc(2'b01, 64'h1e);
    chk("wreq_b3", out_d, {56'h3, 8'h0c});

    // Contention with a wreq arriving mid-rreq
    do_reset();
    beat(0, 56'h10, 1'b0);
    beat(1, 56'h20, 1'b1);
    cyc(2'b10, 64'h2222);
    cyc(2'b01, 64'h1e);
    chk("cont_rresp", out_d, {56'h20, 8'h0b});
    beat(0, 56'h11, 1'b1);
    beat(2, 56'h30, 1'b1);
    cyc(2'b01, 64'h1e);
    chk("cont_rreq1", out_d, {56'h10, 8'h2a});
    cyc(2'b01, 64'h1e);
    chk("cont_rreq2", out_d, {56'h11, 8'h0a});
    cyc(2'b01, 64'h1e);
    chk("cont_wreq", out_d, {56'h30, 8'h0c});

    // Data block between rresp beats
    beat(1, 56'h40, 1'b0);
    cyc(2'b10, 64'h3333);
    beat(1, 56'h41, 1'b1);
    cyc(2'b01, 64'h1e);
    chk("intl_b1", out_d, {56'h40, 8'h2b});
    cyc(2'b10, 64'hdeadbeef);
    chk("intl_data", out_d, 64'hdeadbeef);
    cyc(2'b01, 64'h1e);
    chk("intl_b2", out_d, {56'h41, 8'h0b});

    // Reset in the middle of a three-beat rreq
    beat(0, 56'h50, 1'b0);
    cyc(2'b10, 64'h4444);
    beat(0, 56'h51, 1'b0);
    cyc(2'b01, 64'h1e);
    chk("mid_b1", out_d, {56'h50, 8'h2a});
    do_reset();
    beat(0, 56'h60, 1'b0);
    cyc(2'b10, 64'h6666);
    beat(0, 56'h61, 1'b1);
    cyc(2'b01, 64'h1e);
    chk("post_rst_first", out_d, {56'h60, 8'h2a});
    cyc(2'b01, 64'h1e);
    chk("post_rst_last", out_d, {56'h61, 8'h0a});

    // Repeated rresp/wreq pairs (arbitration order checked by the model)
    repeat (3) begin
      beat(1, 56'h70, 1'b1);
      beat(2, 56'h71, 1'b1);
      cyc(2'b10, 64'h7777);
      cyc(2'b01, 64'h1e);
      cyc(2'b01, 64'h1e);
    end

    // Randomized traffic and message streams
    for (int n = 0; n < 800; n++) begin
      for (int c = 0; c < 3; c++) begin
        if (rem[c] == 0) rem[c] = $urandom_range(1, 4);
        sv[c] = ($urandom_range(0, 2) != 0);
        sd[c] = 56'({$urandom(), $urandom()});
        sl[c] = (rem[c] == 1);
      end
      r = $urandom_range(0, 9);
      if (r < 5) begin
        rh = 2'b01;
        rd = 64'h1e;
      end else if (r < 7) begin
        rh = 2'b10;
        rd = {$urandom(), $urandom()};
      end else if (r == 7) begin
        rh = 2'b01;
        rd = {$urandom(), $urandom()};
        rd[7:0] = ctl_types[$urandom_range(0, 5)];
      end else if (r == 8) begin
        rh = 2'b01;
        rd = {$urandom(), $urandom()};
        rd[7:0] = 8'h1e;
        rd[8]   = 1'b1;
      end else begin
        rh = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'b11;
        rd = 64'h1e;
      end
      cyc(rh, rd);
      for (int c = 0; c < 3; c++) if (acc[c]) rem[c]--;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ipg_tx.md
# ipg_tx

Transmit-side IPG message inserter for the 64b/66b PHY path. Sits between the MAC's 64b/66b encoder and the PHY scrambler/gearbox. It accepts read-request, read-response and write messages as 56-bit beats and places each beat into an all-idle control block (block type 0x1e, payload zero), rewriting the block type to the matching message type. All other blocks pass through unchanged, so ordinary Ethernet traffic is not disturbed.

## Interface
Parameters:
- none. Beat width is fixed at 56 bits and block-type codes are fixed localparams.

Ports:
- `clk`  in  1  PHY TX clock.
- `rst`  in  1  Reset, asynchronous and active-high.
- `encoded_tx_data`  in  64  Encoded block from the MAC encoder.
- `encoded_tx_hdr`  in  2  Sync header: 2'b10 is data, 2'b01 is control.
- `out_encoded_tx_data`  out  64  Block sent to the PHY, registered.
- `out_encoded_tx_hdr`  out  2  Sync header sent to the PHY, registered.
- `s_rreq_data` / `s_rresp_data` / `s_wreq_data`  in  56  Message beat payload for each channel.
- `s_rreq_valid` / `s_rresp_valid` / `s_wreq_valid`  in  1  Beat valid for each channel.
- `s_rreq_last` / `s_rresp_last` / `s_wreq_last`  in  1  Beat is the final beat of its message.
- `s_rreq_ready` / `s_rresp_ready` / `s_wreq_ready`  out  1  Channel can accept a beat.
- `tx_ipg_count`  out  32  Count of inserted blocks; wraps modulo 2^32.

## Operation
- **Per-channel hold register.** Each channel has a one-entry hold register: `hold_valid`, 56-bit data, `last`, and `first`.
  - `s_X_ready = !hold_valid || drain_X`. This is a combinational path from `encoded_tx_*`.
  - A beat transfers into the hold register when valid and ready are both high.
  - `first` is set when the beat is the first beat the channel has accepted since reset or since its previous `last`.
- **Opportunity.** An opportunity exists when `encoded_tx_hdr==2'b01`, `encoded_tx_data[7:0]==8'h1e` and `encoded_tx_data[63:8]==0`. Nothing else is ever overwritten, including idle-like blocks with nonzero control codes and the 0x2d/0x33/0x4b/0x87 types.
- **Arbiter FSM:**
  - States are IDLE, LOCK_RREQ, LOCK_RRESP and LOCK_WREQ.
  - In IDLE, on an opportunity with at least one channel holding a beat, grant by fixed priority: rresp, then wreq, then rreq.
  - If the granted beat is not `last`, move to the corresponding LOCK state.
  - In LOCK_X, only channel X may use opportunities. Return to IDLE after X's `last` beat drains. Messages are never interleaved.
- **Drain.** The granted channel's beat replaces the block:
  - `[63:8]` takes the payload.
  - `[7:0]` takes the type code:
    - FIRST (0x2a / 0x2b / 0x2c for rreq / rresp / wreq) when `first && !last`.
    - middle (0x1a / 0x1b / 0x1c) when `!first && !last`.
    - LAST (0x0a / 0x0b / 0x0c) when `last`. A single-beat message is sent as a LAST type only.
  - The header stays 2'b01, and `tx_ipg_count` increments.
- **Pass-through.** Data blocks, non-idle control blocks, invalid headers (00/11), and idle blocks with nothing to send pass through unchanged.

## Timing
- Latency is exactly 1 cycle from input to output for every block, inserted or not.
- A beat present in the hold register at cycle t with an opportunity at t appears on the output at t+1.
- Throughput is at most one beat per channel per cycle. Back-to-back idle blocks carry consecutive beats.
- Reset values:
  - `out_encoded_tx_data = 64'h1e`, `out_encoded_tx_hdr = 2'b01`.
  - All hold registers empty and all `first` flags set.
  - FSM in IDLE and `tx_ipg_count = 0`.
  - Each `s_X_ready` reads 1 during reset.
- Simultaneous load and drain on the same channel in the same cycle is legal: the hold register takes the new beat.
- A locked channel with an empty hold register leaves opportunities unused. Idle blocks pass unchanged and the lock is held.
- Reset mid-message aborts the message. The receiver sees no LAST, and the next beat accepted after reset is marked FIRST.
- `tx_ipg_count` wraps from 0xFFFFFFFF to 0.

## Configuration
- **`IPG_TX_RR_EN` defined:** in IDLE the arbiter is round-robin. The channel granted most recently has lowest priority, with the base order rresp → wreq → rreq. The pointer updates when a message's LAST beat drains.
- **`IPG_TX_RR_EN` undefined:** fixed priority rresp > wreq > rreq, as described above.

## Test plan
- **Pass-through.** A data block `hdr=2'b10, data=64'h0123456789abcdef` and a control block `data=64'h00000000000000_87` leave unchanged one cycle later; `tx_ipg_count` stays 0.
- **Single-beat rreq.** `s_rreq_data=56'hAABBCCDDEEFF11`, `last=1`, then an idle 0x1e block → output `64'hAABBCCDDEEFF11_0a`, `hdr=2'b01`, `tx_ipg_count=1`.
- **Three-beat wreq over idle.** Beats 56'h1, 56'h2, 56'h3 over consecutive idle blocks → type bytes 0x2c, 0x1c, 0x0c on three consecutive outputs; `s_wreq_ready` stays 1 throughout.
- **Contention.** rreq (2 beats) and rresp (1 beat) both pending, fixed priority → rresp 0x0b goes first, then rreq 0x2a, 0x0a. When a wreq arrives mid-rreq message it waits until after the rreq 0x0a.
- **Data interleave.** A data block arrives between beats of a 2-beat rresp → the data block passes untouched and beat 2 (0x0b) waits for the next idle block.
- **Reset mid-message.** Assert `rst` after beat 1 (0x2a) of a 3-beat rreq → output returns to 64'h1e, count is 0, ready is 1. The next rreq beat goes out as 0x2a. With `IPG_TX_RR_EN` defined, a back-to-back rresp/wreq pair alternates grants.
